mem_wb_writeback: RTL and testbench

MEM/WB pipeline register and writeback selector for the 32-bit pipelined MIPS core; it is the writer side of the register-file write port (`RegWrite`, `WriteReg`, `WriteData`). It captures MEM-stage results each cycle, applies load-size extraction and result selection, and drives the register file. It also exports a same-cycle forwarding view of the pending write.

---
 rtl/mem_wb_writeback.sv | 127 ++++++++++++
 tb/tb_mem_wb_writeback.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and writeback selector with a same-cycle forwarding view.
// Optional retire counter enabled by defining WB_RETIRE_COUNT_EN.
module mem_wb_writeback #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_RegWrite,
  input  logic [1:0]        mem_MemtoReg,
  input  logic [2:0]        mem_LoadType,
  input  logic [REG_AW-1:0] mem_WriteReg,
  input  logic [DATA_W-1:0] mem_ALUResult,
  input  logic [DATA_W-1:0] mem_ReadData,
  input  logic [DATA_W-1:0] mem_PCPlus4,
  output logic              RegWrite,
  output logic [REG_AW-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [31:0]       retire_count
`endif
);

  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [1:0]        memtoreg;
    logic [2:0]        loadtype;
    logic [REG_AW-1:0] wreg;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] pc4;
  } wb_t;

  wb_t wb_q, wb_d;

  // NOTE: wb_d starts as a copy of wb_q so every path assigns it; no latch is inferred.
  always_comb begin
    wb_d = wb_q;
    if (flush) begin
      wb_d.valid    = 1'b0;
      wb_d.regwrite = 1'b0;
    end else if (!stall) begin
      wb_d.valid    = mem_valid;
      wb_d.regwrite = mem_RegWrite;
      wb_d.memtoreg = mem_MemtoReg;
      wb_d.loadtype = mem_LoadType;
      wb_d.wreg     = mem_WriteReg;
      wb_d.alu      = mem_ALUResult;
      wb_d.rdata    = mem_ReadData;
      wb_d.pc4      = mem_PCPlus4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wb_q <= '0;
    else     wb_q <= wb_d;
  end

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] wdata;

  // Little-endian lanes: the low address bits pick the byte/halfword.
  always_comb begin
    byte_sel = wb_q.rdata[7:0];
    case (wb_q.alu[1:0])
      2'd1:    byte_sel = wb_q.rdata[15:8];
      2'd2:    byte_sel = wb_q.rdata[23:16];
      2'd3:    byte_sel = wb_q.rdata[31:24];
      default: byte_sel = wb_q.rdata[7:0];
    endcase
    half_sel = wb_q.alu[1] ? wb_q.rdata[31:16] : wb_q.rdata[15:0];
  end

  always_comb begin
    case (wb_q.loadtype)
      3'b001:  load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      3'b010:  load_data = {{(DATA_W-8){1'b0}}, byte_sel};
      3'b011:  load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      3'b100:  load_data = {{(DATA_W-16){1'b0}}, half_sel};
      default: load_data = wb_q.rdata;
    endcase
  end

  always_comb begin
    case (wb_q.memtoreg)
      2'b01:   wdata = load_data;
      2'b10:   wdata = wb_q.pc4;
      default: wdata = wb_q.alu;
    endcase
  end

  // The register file does not guard index 0, so $zero writes die here.
  assign RegWrite  = wb_q.valid & wb_q.regwrite & (wb_q.wreg != '0);
  assign WriteReg  = wb_q.wreg;
  assign WriteData = wdata;
  assign fwd_valid = RegWrite;
  assign fwd_reg   = WriteReg;
  assign fwd_data  = WriteData;

`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retire_q, retire_d;

  always_comb begin
    retire_d = retire_q;
    if (wb_q.valid && !stall) retire_d = retire_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retire_q <= '0;
    else     retire_q <= retire_d;
  end

  assign retire_count = retire_q;
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Randomised self-checking bench for mem_wb_writeback against a per-entry behavioural model.
// Retire counter checks compile only when WB_RETIRE_COUNT_EN is defined.
module tb_mem_wb_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush;
  logic        mem_valid, mem_RegWrite;
  logic [1:0]  mem_MemtoReg;
  logic [2:0]  mem_LoadType;
  logic [4:0]  mem_WriteReg;
  logic [31:0] mem_ALUResult, mem_ReadData, mem_PCPlus4;
  logic        RegWrite, fwd_valid;
  logic [4:0]  WriteReg, fwd_reg;
  logic [31:0] WriteData, fwd_data;
`ifdef WB_RETIRE_COUNT_EN
  logic [31:0] retire_count;
  logic [31:0] m_ret;
`endif

  int total = 0;
  int bad   = 0;

  // Model: the pending write as it will be presented, computed at capture time.
  logic        m_valid, m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;

  mem_wb_writeback dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite),
    .mem_MemtoReg(mem_MemtoReg), .mem_LoadType(mem_LoadType),
    .mem_WriteReg(mem_WriteReg), .mem_ALUResult(mem_ALUResult),
    .mem_ReadData(mem_ReadData), .mem_PCPlus4(mem_PCPlus4),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
`ifdef WB_RETIRE_COUNT_EN
    , .retire_count(retire_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_data(input logic [1:0] mt, input logic [2:0] lt,
                                           input logic [31:0] alu, input logic [31:0] rd,
                                           input logic [31:0] pc4);
    int unsigned b, h;
    logic [31:0] ld;
    b = (rd >> (8 * (alu & 3))) & 32'hFF;
    h = (rd >> (8 * (alu & 2))) & 32'hFFFF;
    case (lt)
      3'd1:    ld = (b >= 128)   ? b - 256   : b;
      3'd2:    ld = b;
      3'd3:    ld = (h >= 32768) ? h - 65536 : h;
      3'd4:    ld = h;
      default: ld = rd;
    endcase
    if (mt == 2'd1)      return ld;
    else if (mt == 2'd2) return pc4;
    else                 return alu;
  endfunction

  function automatic logic exp_we();
    return m_valid && m_we && (m_reg != 5'd0);
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".RegWrite"},  {31'd0, RegWrite},  {31'd0, exp_we()});
    check({tag, ".fwd_valid"}, {31'd0, fwd_valid}, {31'd0, exp_we()});
    if (exp_we()) begin
      check({tag, ".WriteReg"},  {27'd0, WriteReg}, {27'd0, m_reg});
      check({tag, ".WriteData"}, WriteData, m_data);
      check({tag, ".fwd_reg"},   {27'd0, fwd_reg},  {27'd0, m_reg});
      check({tag, ".fwd_data"},  fwd_data, m_data);
    end
`ifdef WB_RETIRE_COUNT_EN
    check({tag, ".retire"}, retire_count, m_ret);
`endif
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_we = 1'b0; m_reg = '0; m_data = '0;
`ifdef WB_RETIRE_COUNT_EN
    m_ret = '0;
`endif
  endtask

  // Drive one cycle of inputs at the falling edge, update the model at the rising edge, then check.
  task automatic step(input string tag, input logic v, input logic we, input logic [1:0] mt,
                      input logic [2:0] lt, input logic [4:0] wr, input logic [31:0] alu,
                      input logic [31:0] rd, input logic [31:0] pc4, input logic st,
                      input logic fl);
    @(negedge clk);
    mem_valid = v; mem_RegWrite = we; mem_MemtoReg = mt; mem_LoadType = lt;
    mem_WriteReg = wr; mem_ALUResult = alu; mem_ReadData = rd; mem_PCPlus4 = pc4;
    stall = st; flush = fl;
    @(posedge clk);
`ifdef WB_RETIRE_COUNT_EN
    if (m_valid && !st) m_ret = m_ret + 32'd1;
`endif
    if (fl) begin
      m_valid = 1'b0; m_we = 1'b0;
    end else if (!st) begin
      m_valid = v; m_we = we; m_reg = wr;
      m_data = ref_data(mt, lt, alu, rd, pc4);
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".RegWrite"},  {31'd0, RegWrite},  32'd0);
    check({tag, ".WriteReg"},  {27'd0, WriteReg},  32'd0);
    check({tag, ".WriteData"}, WriteData,          32'd0);
    check({tag, ".fwd_valid"}, {31'd0, fwd_valid}, 32'd0);
    check({tag, ".fwd_reg"},   {27'd0, fwd_reg},   32'd0);
    check({tag, ".fwd_data"},  fwd_data,           32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    mem_valid = 1'b0; mem_RegWrite = 1'b0; mem_MemtoReg = '0; mem_LoadType = '0;
    mem_WriteReg = '0; mem_ALUResult = '0; mem_ReadData = '0; mem_PCPlus4 = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    step("alu", 1, 1, 2'b00, 3'd0, 5'd8, 32'd30, 32'hDEAD_BEEF, 32'h100, 0, 0);
    check("alu.WriteData_const", WriteData, 32'd30);

    step("lb",  1, 1, 2'b01, 3'd1, 5'd3, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 0, 0);
    check("lb_const", WriteData, 32'hFFFF_FFFF);
    step("lbu", 1, 1, 2'b01, 3'd2, 5'd3, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 0, 0);
    check("lbu_const", WriteData, 32'h0000_00FF);
    step("lh",  1, 1, 2'b01, 3'd3, 5'd3, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 0, 0);
    check("lh_const", WriteData, 32'hFFFF_80FF);
    step("lhu", 1, 1, 2'b01, 3'd4, 5'd3, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 0, 0);
    check("lhu_const", WriteData, 32'h0000_80FF);
    step("lw",  1, 1, 2'b01, 3'd0, 5'd3, 32'h0000_1002, 32'h80FF_7F01, 32'h0, 0, 0);
    check("lw_const", WriteData, 32'h80FF_7F01);

    step("zero", 1, 1, 2'b00, 3'd0, 5'd0, 32'h1234, 32'h0, 32'h0, 0, 0);
    check("zero.RegWrite_const", {31'd0, RegWrite}, 32'd0);
    step("link", 1, 1, 2'b10, 3'd0, 5'd31, 32'h7777, 32'h0, 32'h40, 0, 0);
    check("link.WriteData_const", WriteData, 32'h40);

    step("hold_src", 1, 1, 2'b00, 3'd0, 5'd5, 32'hCAFE_0005, 32'h0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("stall", 1, 1, 2'b00, 3'd0, 5'd9, $urandom, $urandom, $urandom, 1, 0);
      check("stall.RegWrite_const", {31'd0, RegWrite}, 32'd1);
      check("stall.WriteData_const", WriteData, 32'hCAFE_0005);
    end
    step("flush_stall", 1, 1, 2'b00, 3'd0, 5'd9, 32'h99, 32'h0, 32'h0, 1, 1);
    check("flush_stall.RegWrite_const", {31'd0, RegWrite}, 32'd0);

    step("pre_rst", 1, 1, 2'b00, 3'd0, 5'd12, 32'hA5A5_0012, 32'h0, 32'h0, 0, 0);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    #1 rst = 1'b0;

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom % 4) != 0, $urandom % 2, 2'($urandom % 4), 3'($urandom % 8),
           5'($urandom % 32), $urandom, $urandom, $urandom,
           ($urandom % 5) == 0, ($urandom % 9) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
